float_to_fixed_pipe: RTL and testbench
======================================

Name: float_to_fixed_pipe

Overview:
- Parametrised, pipelined converter from IEEE-754 single-precision to a saturated fixed-point integer.
- Computes out = sat(round((a + OFFSET) * 2^SCALE_SHIFT)).
- Next generation of the neuron-unit float-to-int16 path. Output width, offset, scale, signedness and rounding are configurable.
- Registered valid/ready handshake; NaN and saturation flags.
- Sits between the FP neuron datapath and integer consumers such as the activation LUT and quantised memory.

Parameters:
- OUT_W, 16, output integer width (4..32).
- SCALE_SHIFT, 5, power-of-two scale exponent (0..16).
- OFFSET, 1024, signed integer added to the input before scaling.
- SIGNED_OUT, 0: 0 = unsigned range [0, 2^OUT_W-1]; 1 = two's complement [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- ROUND_MODE, 1: 0 = floor (toward -inf); 1 = round-to-nearest-even.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  converter can accept an input this cycle.
- in_data  in  32  IEEE-754 single.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W  converted value.
- out_sat  out  1  result was clamped (overflow, underflow or ±Inf).
- out_nan  out  1  input was NaN; out_data = 0.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While rst=1 at a clock edge, all stage valids clear. Outputs reset to: out_valid=0, out_data=0, out_sat=0, out_nan=0, in_ready=1 (the combinational form below evaluates to 1 once stage valids are 0).
- Reset mid-operation discards in-flight data; no partial result is emitted.
- Transfer rules: an input transfers when in_valid & in_ready; an output transfers when out_valid & out_ready.
- Stall: the pipeline advances only when !v3 | out_ready, and in_ready equals that term. This is combinational from out_ready; the stall is global, with no bubble collapsing.
- Throughput and latency: 1 word/cycle when unstalled. Latency is 3 cycles from the accept edge to out_valid=1.
- While out_valid=1 & out_ready=0, out_data, out_sat and out_nan hold stable.
- Stage 1 (unpack/classify): register sign, exponent e, mantissa with hidden bit, and class flags: zero (e=0, subnormals flushed to zero; -0 treated as 0), inf, nan.
- Stage 2 (align): form signed fixed-point magnitude of a * 2^SCALE_SHIFT.
  - Integer field is OUT_W+2 bits, plus one round bit and one sticky bit (OR of all discarded bits).
  - Effective exponent e-127+SCALE_SHIFT above the representable integer field sets a pre-overflow flag.
  - Exponent below -2 yields zero integer and round bit, with sticky = (mantissa != 0).
  - Negate (two's complement across integer+round+sticky) when sign=1.
- Stage 3 (offset/round/saturate):
  - Add OFFSET * 2^SCALE_SHIFT, sign-extended, exactly.
  - ROUND_MODE=1: increment when round=1 & (sticky | lsb).
  - ROUND_MODE=0: keep the floor, i.e. drop the round and sticky bits of the two's-complement value.
  - Clamp to the selected range; out_sat=1 on clamp.
- Special cases:
  - +Inf gives max with out_sat=1; -Inf gives min with out_sat=1.
  - NaN gives out_data=0, out_nan=1, out_sat=0.
  - Pre-overflow is treated as ±Inf by sign, after the offset is considered.
- Exactly representable in-range results must be bit-exact.

Test Plan:
- Reset, then in_data=0x00000000 (0.0) with out_ready=1: out_data=0x8000 exactly 3 cycles after accept; sat=0, nan=0.
- in_data=0x3FC00000 (1.5): out_data=0x8030. in_data=0xC4800000 (-1024.0): out_data=0x0000, sat=0.
- Saturation: 0x44800000 (1024.0) gives 0xFFFF, sat=1. 0xC4FA0000 (-2000.0) gives 0x0000, sat=1. +Inf gives 0xFFFF, sat=1. 0x7FC00000 (NaN) gives 0x0000, nan=1.
- Rounding: 0x3D400000 (0.046875, scaled 32769.5) gives 32770 with ROUND_MODE=1 and 32769 with ROUND_MODE=0. 0x3C800000 (scaled 32768.5) gives 32768 in both modes.
- Back-pressure: stream 6 back-to-back words, holding out_ready=0 for 4 cycles mid-stream. No loss or duplication, order preserved, outputs stable while stalled, in_ready=0 during the stall.
- Reset mid-stream with 3 words in flight: after reset, out_valid=0 and the next accepted word emerges 3 cycles later. Repeat with SIGNED_OUT=1, OUT_W=8, OFFSET=0, SCALE_SHIFT=0: -200.0 gives 0x80 with sat=1, and -3.5 gives 0xFC (RNE) or 0xFC (floor).

Source files
------------

// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe
//   Three-stage converter from IEEE-754 single precision to a saturated
//   fixed-point integer: out = sat(round((a + OFFSET) * 2^SCALE_SHIFT)).
//   Stage 1 unpacks and classifies the float, stage 2 aligns the magnitude
//   to OUT_W+2 integer bits plus a round and a sticky bit (then applies the
//   sign), and stage 3 adds the scaled offset, rounds and clamps.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational from out_ready)
//   in_data[31:0]         IEEE-754 single
//   out_valid / out_ready output handshake
//   out_data[OUT_W-1:0]   converted value
//   out_sat               result was clamped (overflow, underflow or +/-Inf)
//   out_nan               input was NaN (out_data forced to 0)
module float_to_fixed_pipe #(
  parameter int OUT_W       = 16,
  parameter int SCALE_SHIFT = 5,
  parameter int OFFSET      = 1024,
  parameter int SIGNED_OUT  = 0,
  parameter int ROUND_MODE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_nan
);

  localparam int IW  = OUT_W + 2;  // integer field width of the aligned magnitude
  localparam int IRW = IW + 1;     // integer field plus round bit
  localparam int SW  = IW + 3;     // sign + integer + round + sticky

  // Offset in the same fixed-point grid as the stage-2 value (2 fraction bits).
  localparam logic signed [63:0] OFF_FX = 64'(longint'(OFFSET) * (longint'(1) <<< (SCALE_SHIFT + 2)));
  localparam logic signed [63:0] MAX_V  = (SIGNED_OUT != 0) ? ((64'sd1 <<< (OUT_W - 1)) - 64'sd1)
                                                             : ((64'sd1 <<< OUT_W) - 64'sd1);
  localparam logic signed [63:0] MIN_V  = (SIGNED_OUT != 0) ? -(64'sd1 <<< (OUT_W - 1)) : 64'sd0;

  // Global stall: every stage moves together or not at all.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- Stage 1: unpack / classify ----------------
  logic        v1_q, v1_d;
  logic        s1_sign_q, s1_sign_d;
  logic [7:0]  s1_exp_q, s1_exp_d;
  logic [23:0] s1_mant_q, s1_mant_d;
  logic        s1_zero_q, s1_zero_d;
  logic        s1_inf_q, s1_inf_d;
  logic        s1_nan_q, s1_nan_d;

  always_comb begin
    v1_d      = v1_q;
    s1_sign_d = s1_sign_q;
    s1_exp_d  = s1_exp_q;
    s1_mant_d = s1_mant_q;
    s1_zero_d = s1_zero_q;
    s1_inf_d  = s1_inf_q;
    s1_nan_d  = s1_nan_q;
    if (advance) begin
      v1_d      = in_valid;
      s1_sign_d = in_data[31];
      s1_exp_d  = in_data[30:23];
      s1_mant_d = {1'b1, in_data[22:0]};
      // Subnormals and -0 are flushed to a plain zero.
      s1_zero_d = (in_data[30:23] == 8'd0);
      s1_inf_d  = (in_data[30:23] == 8'hFF) && (in_data[22:0] == 23'd0);
      s1_nan_d  = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    end
  end

  // ---------------- Stage 2: align and apply sign ----------------
  logic                 v2_q, v2_d;
  logic signed [SW-1:0] s2_val_q, s2_val_d;
  logic                 s2_sign_q, s2_sign_d;
  logic                 s2_inf_q, s2_inf_d;
  logic                 s2_nan_q, s2_nan_d;

  int                   ee;
  logic [63:0]          m64;
  logic [5:0]           lsh, rsh;
  logic [IRW-1:0]       ir;
  logic                 sticky;
  logic                 ovf;
  logic signed [SW-1:0] mag;

  always_comb begin
    // ee is the power of two of the hidden bit after scaling.
    ee     = int'(s1_exp_q) - 127 + SCALE_SHIFT;
    m64    = 64'(s1_mant_q);
    lsh    = '0;
    rsh    = '0;
    ir     = '0;
    sticky = 1'b0;
    ovf    = 1'b0;
    if (s1_zero_q || s1_inf_q || s1_nan_q) begin
      ir = '0;
    end else if (ee >= IW) begin
      ovf = 1'b1;
    end else if (ee >= 22) begin
      // The mantissa LSB lands at or above the round bit: pure left shift.
      lsh = 6'(ee - 22);
      ir  = IRW'(m64 << lsh);
    end else if (ee >= -2) begin
      rsh    = 6'(22 - ee);
      ir     = IRW'(m64 >> rsh);
      sticky = |(m64 & ((64'd1 << rsh) - 64'd1));
    end else begin
      sticky = |s1_mant_q;
    end
    mag = {1'b0, ir, sticky};

    v2_d      = v2_q;
    s2_val_d  = s2_val_q;
    s2_sign_d = s2_sign_q;
    s2_inf_d  = s2_inf_q;
    s2_nan_d  = s2_nan_q;
    if (advance) begin
      v2_d      = v1_q;
      s2_val_d  = s1_sign_q ? -mag : mag;
      s2_sign_d = s1_sign_q;
      s2_inf_d  = s1_inf_q || ovf;
      s2_nan_d  = s1_nan_q;
    end
  end

  // ---------------- Stage 3: offset / round / saturate ----------------
  logic             v3_q, v3_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic             out_nan_q, out_nan_d;

  logic signed [63:0] sum, flr, rnd, res;
  logic               clamp;

  always_comb begin
    sum = 64'(s2_val_q) + OFF_FX;
    // Floor of a two's-complement value is the arithmetic shift; the two
    // dropped bits are then the (non-negative) round and sticky fraction.
    flr = sum >>> 2;
    rnd = flr;
    if (ROUND_MODE == 1 && sum[1] && (sum[0] || sum[2])) begin
      rnd = flr + 64'sd1;
    end
    res   = rnd;
    clamp = 1'b0;
    if (rnd > MAX_V) begin
      res   = MAX_V;
      clamp = 1'b1;
    end else if (rnd < MIN_V) begin
      res   = MIN_V;
      clamp = 1'b1;
    end

    v3_d       = v3_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    out_nan_d  = out_nan_q;
    if (advance) begin
      v3_d = v2_q;
      if (s2_nan_q) begin
        out_data_d = '0;
        out_sat_d  = 1'b0;
        out_nan_d  = 1'b1;
      end else if (s2_inf_q) begin
        out_data_d = s2_sign_q ? OUT_W'(MIN_V) : OUT_W'(MAX_V);
        out_sat_d  = 1'b1;
        out_nan_d  = 1'b0;
      end else begin
        out_data_d = OUT_W'(res);
        out_sat_d  = clamp;
        out_nan_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s1_zero_q  <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_nan_q   <= 1'b0;
      v2_q       <= 1'b0;
      s2_val_q   <= '0;
      s2_sign_q  <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_nan_q   <= 1'b0;
      v3_q       <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      out_nan_q  <= 1'b0;
    end else begin
      v1_q       <= v1_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_mant_q  <= s1_mant_d;
      s1_zero_q  <= s1_zero_d;
      s1_inf_q   <= s1_inf_d;
      s1_nan_q   <= s1_nan_d;
      v2_q       <= v2_d;
      s2_val_q   <= s2_val_d;
      s2_sign_q  <= s2_sign_d;
      s2_inf_q   <= s2_inf_d;
      s2_nan_q   <= s2_nan_d;
      v3_q       <= v3_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      out_nan_q  <= out_nan_d;
    end
  end

  assign out_valid = v3_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_nan   = out_nan_q;

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Directed-vector bench for float_to_fixed_pipe. Four instances share one
// input bus: u0 default (u16, offset 1024, shift 5, RNE), u1 the same with
// floor rounding, u2/u3 signed 8-bit, offset 0, shift 0, RNE / floor.
module tb_float_to_fixed_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic [3:0]  irdy, ov, osat, onan;
  logic [15:0] d0, d1;
  logic [7:0]  d2, d3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  float_to_fixed_pipe #(.OUT_W(16), .SCALE_SHIFT(5), .OFFSET(1024), .SIGNED_OUT(0), .ROUND_MODE(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(d0), .out_sat(osat[0]), .out_nan(onan[0]));
  float_to_fixed_pipe #(.OUT_W(16), .SCALE_SHIFT(5), .OFFSET(1024), .SIGNED_OUT(0), .ROUND_MODE(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(d1), .out_sat(osat[1]), .out_nan(onan[1]));
  float_to_fixed_pipe #(.OUT_W(8), .SCALE_SHIFT(0), .OFFSET(0), .SIGNED_OUT(1), .ROUND_MODE(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(d2), .out_sat(osat[2]), .out_nan(onan[2]));
  float_to_fixed_pipe #(.OUT_W(8), .SCALE_SHIFT(0), .OFFSET(0), .SIGNED_OUT(1), .ROUND_MODE(0)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[3]), .in_data(in_data),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(d3), .out_sat(osat[3]), .out_nan(onan[3]));

  typedef struct {
    int          dut;
    logic [31:0] din;
    logic [31:0] exp_data;
    logic        exp_sat;
    logic        exp_nan;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] dget(input int d);
    case (d)
      0:       return {16'd0, d0};
      1:       return {16'd0, d1};
      2:       return {24'd0, d2};
      default: return {24'd0, d3};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic add(input int d, input logic [31:0] din, input logic [31:0] e, input logic s, input logic n);
    vec_t v;
    v.dut = d; v.din = din; v.exp_data = e; v.exp_sat = s; v.exp_nan = n;
    vecs.push_back(v);
  endtask

  // Present one word, then count cycles from the accept cycle (cycle 0)
  // to the cycle in which out_valid of instance d is first seen.
  task automatic send_one(input int d, input logic [31:0] din,
                          output logic [31:0] data, output logic s, output logic n, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = din;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!ov[d] && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    data = dget(d);
    s    = osat[d];
    n    = onan[d];
  endtask

  task automatic run_vec(input string tag, input int d, input logic [31:0] din,
                         input logic [31:0] e, input logic s, input logic n);
    logic [31:0] gd;
    logic        gs, gn;
    int          lat;
    send_one(d, din, gd, gs, gn, lat);
    $display("[TB] %s dut%0d in=%08h -> data=%h sat=%b nan=%b lat=%0d", tag, d, din, gd, gs, gn, lat);
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " data"}, gd, e);
    check({tag, " sat"}, {31'd0, gs}, {31'd0, s});
    check({tag, " nan"}, {31'd0, gn}, {31'd0, n});
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, " out_valid"}, {31'd0, ov[i]}, 32'd0);
      check({tag, " in_ready"}, {31'd0, irdy[i]}, 32'd1);
    end
    check({tag, " out_data"}, {16'd0, d0}, 32'd0);
    check({tag, " out_sat"}, {31'd0, osat[0]}, 32'd0);
    check({tag, " out_nan"}, {31'd0, onan[0]}, 32'd0);
  endtask

  // Back-pressure stream data (instance 0).
  logic [31:0] bp_in [6] = '{32'h00000000, 32'h3FC00000, 32'h3F000000,
                             32'hBF800000, 32'h44800000, 32'h7FC00000};
  logic [15:0] bp_exp[6] = '{16'h8000, 16'h8030, 16'h8010, 16'h7FE0, 16'hFFFF, 16'h0000};
  logic        bp_sat[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        bp_nan[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // instance 0: u16, offset 1024, shift 5, RNE
    add(0, 32'h00000000, 32'h8000, 0, 0);
    add(0, 32'h3FC00000, 32'h8030, 0, 0);
    add(0, 32'hC4800000, 32'h0000, 0, 0);
    add(0, 32'h44800000, 32'hFFFF, 1, 0);
    add(0, 32'hC4FA0000, 32'h0000, 1, 0);
    add(0, 32'h7F800000, 32'hFFFF, 1, 0);
    add(0, 32'hFF800000, 32'h0000, 1, 0);
    add(0, 32'h7FC00000, 32'h0000, 0, 1);
    add(0, 32'h3D400000, 32'h8002, 0, 0);
    add(0, 32'h3C800000, 32'h8000, 0, 0);
    add(0, 32'hBC800000, 32'h8000, 0, 0);
    add(0, 32'h80000000, 32'h8000, 0, 0);
    add(0, 32'h00000001, 32'h8000, 0, 0);
    add(0, 32'h447FFE00, 32'hFFFF, 0, 0);
    add(0, 32'h7F000000, 32'hFFFF, 1, 0);
    add(0, 32'hBF800000, 32'h7FE0, 0, 0);
    // instance 1: floor
    add(1, 32'h3D400000, 32'h8001, 0, 0);
    add(1, 32'h3C800000, 32'h8000, 0, 0);
    add(1, 32'hBC800000, 32'h7FFF, 0, 0);
    add(1, 32'h7FC00000, 32'h0000, 0, 1);
    // instance 2: s8, RNE
    add(2, 32'hC3480000, 32'h80, 1, 0);
    add(2, 32'hC0600000, 32'hFC, 0, 0);
    add(2, 32'h40600000, 32'h04, 0, 0);
    add(2, 32'hC0200000, 32'hFE, 0, 0);
    add(2, 32'h42FF0000, 32'h7F, 1, 0);
    add(2, 32'hC3000000, 32'h80, 0, 0);
    add(2, 32'h7F800000, 32'h7F, 1, 0);
    // instance 3: s8, floor
    add(3, 32'hC0600000, 32'hFC, 0, 0);
    add(3, 32'h40600000, 32'h03, 0, 0);
    add(3, 32'hC0200000, 32'hFD, 0, 0);
    add(3, 32'h42FF0000, 32'h7F, 0, 0);
    add(3, 32'hFF800000, 32'h80, 1, 0);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("reset");

    foreach (vecs[i]) begin
      run_vec($sformatf("vec%0d", i), vecs[i].dut, vecs[i].din, vecs[i].exp_data, vecs[i].exp_sat, vecs[i].exp_nan);
    end

    // Back-pressure: 6 back-to-back words, out_ready low for cycles 4..7.
    begin
      int          idx, got, cyc;
      logic        held, stall;
      logic [15:0] hd;
      logic        hs, hn;
      idx = 0; got = 0; cyc = 0; held = 1'b0; hd = '0; hs = 1'b0; hn = 1'b0;
      while (got < 6 && cyc < 60) begin
        @(negedge clk);
        stall     = (cyc >= 4 && cyc < 8);
        in_valid  = (idx < 6);
        in_data   = (idx < 6) ? bp_in[idx] : 32'h0;
        out_ready = !stall;
        #1;
        if (stall && ov[0]) check("bp stall in_ready", {31'd0, irdy[0]}, 32'd0);
        if (held) begin
          check("bp hold data", {16'd0, d0}, {16'd0, hd});
          check("bp hold flags", {30'd0, osat[0], onan[0]}, {30'd0, hs, hn});
        end
        if (ov[0] && out_ready) begin
          $display("[TB] bp out%0d data=%h sat=%b nan=%b", got, d0, osat[0], onan[0]);
          check($sformatf("bp word%0d data", got), {16'd0, d0}, {16'd0, bp_exp[got]});
          check($sformatf("bp word%0d flags", got), {30'd0, osat[0], onan[0]},
                {30'd0, bp_sat[got], bp_nan[got]});
          got++;
        end
        held = ov[0] && !out_ready;
        hd = d0; hs = osat[0]; hn = onan[0];
        if (in_valid && irdy[0]) idx++;
        @(posedge clk);
        cyc++;
      end
      check("bp words received", 32'(got), 32'd6);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) begin
        @(negedge clk);
        check("bp no extra output", {31'd0, ov[0]}, 32'd0);
      end
    end

    // Reset with 3 words in flight and the output stalled.
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h3F800000 + 32'(k);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("midreset");
    run_vec("post-reset u16", 0, 32'h3FC00000, 32'h8030, 0, 0);
    run_vec("post-reset s8", 2, 32'hC3480000, 32'h80, 1, 0);
    run_vec("post-reset s8 floor", 3, 32'hC0600000, 32'hFC, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
